// File: rtl/aes_pkg.sv
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared types and sizes for the AES-256 encryption datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int N  = 16;
    localparam int NR = 14;

    typedef logic [N-1:0][7:0] state_t;
    typedef logic [3:0]        rnd_t;
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} ark_st_t;

    localparam rnd_t C_RND_LAST = rnd_t'(NR);

endpackage

`default_nettype wire

// File: rtl/mod_enc_addroundkey_rkfile.sv
// ============================================================================
// Module  : mod_enc_rkFile
// Brief   : 15-entry round-key file, one synchronous write, one async read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_enc_rkFile
    import aes_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_i,
    input  logic                lock_i,
    input  logic [3:0]          wr_idx_i,
    input  logic [N-1:0][7:0]   wr_key_i,
    input  logic [3:0]          rd_idx_i,
    output logic [N-1:0][7:0]   rd_key_o,
    output logic                wr_err_o
);

    state_t rk_q [NR+1];
    logic   wr_ok;
    logic   err_q;
    logic   err_d;

    assign wr_ok = wr_i && !lock_i && (wr_idx_i <= C_RND_LAST);
    assign err_d = wr_i && !wr_ok;

    // Key storage deliberately has no reset so keys survive a block abort.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            rk_q[wr_idx_i] <= wr_key_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign rd_key_o = (rd_idx_i <= C_RND_LAST) ? rk_q[rd_idx_i] : '0;
    assign wr_err_o = err_q;

endmodule

`default_nettype wire

// File: rtl/mod_enc_addroundkey.sv
// ============================================================================
// Module  : mod_enc_addroundkey
// Brief   : AES-256 AddRoundKey stage with round-key file and round sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_enc_addroundkey
    import aes_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                key_wr_i,
    input  logic [3:0]          key_idx_i,
    input  logic [N-1:0][7:0]   key_i,
    input  logic                start_i,
    input  logic                enable_i,
    input  logic [N-1:0][7:0]   state_i,
    output logic [N-1:0][7:0]   state_o,
    output logic                done_o,
    output logic [3:0]          round_o,
    output logic                last_o,
    output logic                busy_o,
    output logic                key_err_o
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_RUN  = RUN;

    logic [0:0] fsm_q,   fsm_d;
    rnd_t       round_q, round_d;
    state_t     state_q, state_d;
    logic       done_q,  done_d;
    logic       last_q,  last_d;
    rnd_t       cur_round;
    state_t     rd_key;

    mod_enc_rkFile u_rkfile (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wr_i     (key_wr_i),
        .lock_i   (fsm_q == S_RUN),
        .wr_idx_i (key_idx_i),
        .wr_key_i (key_i),
        .rd_idx_i (cur_round),
        .rd_key_o (rd_key),
        .wr_err_o (key_err_o)
    );

    // A start in the same cycle as an enable clears the counter before use.
    assign cur_round = start_i ? rnd_t'(0) : round_q;

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        done_d  = 1'b0;
        last_d  = 1'b0;
        if (start_i) begin
            fsm_d   = S_RUN;
            round_d = '0;
        end
        if (enable_i && (start_i || (fsm_q == S_RUN))) begin
            state_d = state_i ^ rd_key;
            done_d  = 1'b1;
            if (cur_round == C_RND_LAST) begin
                last_d  = 1'b1;
                round_d = '0;
                fsm_d   = S_IDLE;
            end else begin
                round_d = cur_round + 1'b1;
                fsm_d   = S_RUN;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= S_IDLE;
            round_q <= '0;
            state_q <= '0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    assign state_o = state_q;
    assign done_o  = done_q;
    assign round_o = round_q;
    assign last_o  = last_q;
    assign busy_o  = (fsm_q == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_mod_enc_addroundkey.sv
// ============================================================================
// Module  : tb_mod_enc_addroundkey
// Brief   : Self-checking bench for mod_enc_addroundkey with an AES-256 model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_enc_addroundkey;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_wr = 1'b0;
    logic [3:0] key_idx = '0;
    state_t     key = '0;
    logic       start = 1'b0;
    logic       enable = 1'b0;
    state_t     st = '0;
    state_t     state_o;
    logic       done_o, last_o, busy_o, key_err_o;
    logic [3:0] round_o;

    int checks = 0;
    int errors = 0;

    logic [127:0] mk [15];
    logic [127:0] exp_last;
    int           mr;
    bit           mrun;
    logic [7:0]   sbox [256];

    typedef struct {
        logic [127:0] k;
        logic [127:0] s;
        logic [127:0] e;
    } vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

    mod_enc_addroundkey dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .key_wr_i  (key_wr),
        .key_idx_i (key_idx),
        .key_i     (key),
        .start_i   (start),
        .enable_i  (enable),
        .state_i   (st),
        .state_o   (state_o),
        .done_o    (done_o),
        .round_o   (round_o),
        .last_o    (last_o),
        .busy_o    (busy_o),
        .key_err_o (key_err_o)
    );

    // FIPS byte 0 is the leftmost hex pair; the DUT stores it at index 0.
    function automatic state_t to_st(input logic [127:0] v);
        state_t s;
        for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
        return s;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] v, input bit mix);
        logic [7:0] b [16];
        logic [7:0] n [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox[v[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) n[rr+4*c] = b[rr+4*((c+rr)%4)];
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                b[4*c]   = xt(n[4*c]) ^ gmul(n[4*c+1], 8'h03) ^ n[4*c+2] ^ n[4*c+3];
                b[4*c+1] = n[4*c] ^ xt(n[4*c+1]) ^ gmul(n[4*c+2], 8'h03) ^ n[4*c+3];
                b[4*c+2] = n[4*c] ^ n[4*c+1] ^ xt(n[4*c+2]) ^ gmul(n[4*c+3], 8'h03);
                b[4*c+3] = gmul(n[4*c], 8'h03) ^ n[4*c+1] ^ n[4*c+2] ^ xt(n[4*c+3]);
            end
        end else begin
            for (int i = 0; i < 16; i++) b[i] = n[i];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mr = 0;
        mrun = 1'b0;
    endtask

    task automatic load_key(input int idx, input logic [127:0] k);
        bit ok;
        ok = (idx <= NR) && !mrun;
        key_wr = 1'b1;
        key_idx = 4'(idx);
        key = to_st(k);
        tick();
        key_wr = 1'b0;
        if (ok) mk[idx] = k;
        chk($sformatf("key_err_idx%0d", idx), 128'(key_err_o), 128'(!ok));
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        mr = 0;
        mrun = 1'b1;
        chk("start_busy", 128'(busy_o), 128'(1));
        chk("start_round", 128'(round_o), 128'(0));
    endtask

    // One processed round: expected output is input XOR the modelled key.
    task automatic ark_step(input string name, input logic [127:0] s, input bit strt);
        bit is_last;
        enable = 1'b1;
        start = strt;
        st = to_st(s);
        tick();
        enable = 1'b0;
        start = 1'b0;
        if (strt) mr = 0;
        exp_last = s ^ mk[mr];
        is_last = (mr == NR);
        chk({name, "_state"}, state_o, to_st(exp_last));
        chk({name, "_done"}, 128'(done_o), 128'(1));
        chk({name, "_last"}, 128'(last_o), 128'(is_last));
        mr = is_last ? 0 : mr + 1;
        mrun = !is_last;
        chk({name, "_round"}, 128'(round_o), 128'(mr));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [31:0]  w [60];
        logic [127:0] ark_in [15];
        logic [255:0] k256;
        logic [7:0]   rcon;
        logic [7:0]   inv;
        logic [31:0]  t;
        logic [127:0] s;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end

        mr = 0;
        mrun = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_state", state_o, '0);
        chk("rst_flags", {done_o, last_o, busy_o, key_err_o, round_o}, '0);
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: basic round 0
        load_key(0, 128'h000102030405060708090a0b0c0d0e0f);
        load_key(1, 128'h101112131415161718191a1b1c1d1e1f);
        do_start();
        enable = 1'b1;
        st = to_st(128'h00112233445566778899aabbccddeeff);
        tick();
        enable = 1'b0;
        chk("t1_state", state_o, to_st(128'h00102030405060708090a0b0c0d0e0f0));
        chk("t1_done", 128'(done_o), 128'(1));
        chk("t1_round", 128'(round_o), 128'(1));
        chk("t1_last", 128'(last_o), 128'(0));
        tick();
        chk("t1_hold_done", 128'(done_o), 128'(0));
        chk("t1_hold_state", state_o, to_st(128'h00102030405060708090a0b0c0d0e0f0));

        // Table: reset (keys survive), load rk0, start+enable from IDLE
        tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                   128'h00102030405060708090a0b0c0d0e0f0};
        tbl[1] = '{128'hffffffffffffffffffffffffffffffff, 128'h0, 128'hffffffffffffffffffffffffffffffff};
        for (int i = 2; i < 5; i++) begin
            tbl[i].k = rnd128();
            tbl[i].s = rnd128();
            tbl[i].e = tbl[i].k ^ tbl[i].s;
        end
        for (int i = 0; i < 5; i++) begin
            do_reset();
            load_key(0, tbl[i].k);
            enable = 1'b1;
            start = 1'b1;
            st = to_st(tbl[i].s);
            tick();
            enable = 1'b0;
            start = 1'b0;
            chk($sformatf("tbl%0d_state", i), state_o, to_st(tbl[i].e));
            chk($sformatf("tbl%0d_flags", i), {done_o, last_o, busy_o, round_o}, {3'b101, 4'd1});
        end

        // Test 2: FIPS-197 C.3 full block
        do_reset();
        k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        for (int i = 0; i < 8; i++) w[i] = k256[255-32*i -: 32];
        rcon = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) load_key(r, {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
        ark_in[0] = 128'h00112233445566778899aabbccddeeff;
        for (int r = 1; r < 15; r++) ark_in[r] = aes_round(ark_in[r-1] ^ mk[r-1], r != NR);
        do_start();
        for (int r = 0; r < 15; r++) ark_step($sformatf("c3_r%0d", r), ark_in[r], 1'b0);
        chk("c3_cipher", state_o, to_st(128'h8ea2b7ca516745bfeafc49904b496089));
        chk("c3_end", {busy_o, round_o}, '0);

        // Test 3: rejected key writes
        load_key(15, rnd128());
        tick();
        chk("t3_err_pulse", 128'(key_err_o), 128'(0));
        do_start();
        load_key(3, rnd128());
        for (int r = 0; r < 15; r++) ark_step($sformatf("t3_rb%0d", r), 128'h0, 1'b0);

        // Test 4: restart mid-block at round 5
        do_start();
        for (int r = 0; r < 5; r++) ark_step("t4_pre", rnd128(), 1'b0);
        chk("t4_round5", 128'(round_o), 128'(5));
        ark_step("t4_restart", rnd128(), 1'b1);

        // Test 5: async reset during round 7
        for (int r = 1; r < 7; r++) ark_step("t5_pre", rnd128(), 1'b0);
        chk("t5_round7", 128'(round_o), 128'(7));
        rst_n = 1'b0;
        #1;
        chk("t5_rst_state", state_o, '0);
        chk("t5_rst_flags", {done_o, last_o, busy_o, key_err_o, round_o}, '0);
        tick();
        rst_n = 1'b1;
        mr = 0;
        mrun = 1'b0;
        enable = 1'b1;
        st = to_st(rnd128());
        tick();
        enable = 1'b0;
        chk("t5_noen_done", {done_o, busy_o}, '0);
        do_start();
        for (int r = 0; r < 15; r++) ark_step($sformatf("t5_r%0d", r), rnd128(), 1'b0);

        // Test 6: enable in IDLE is ignored
        enable = 1'b1;
        st = to_st(rnd128());
        tick();
        enable = 1'b0;
        chk("t6_done", 128'(done_o), 128'(0));
        chk("t6_hold", state_o, to_st(exp_last));

        // Random blocks with fresh random key files
        for (int b = 0; b < 3; b++) begin
            for (int r = 0; r < 15; r++) load_key(r, rnd128());
            do_start();
            for (int r = 0; r < 15; r++) begin
                s = rnd128();
                ark_step($sformatf("rnd%0d_r%0d", b, r), s, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
